// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// The instruction ROM is external and reads combinationally from imem_addr.
// Optional build macro IF_PERF_CNT_EN adds fetch/stall/bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 6,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc,
  output logic [31:0]        if_id_inst,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic               if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        bubble_cnt
`endif
);

  logic [31:0] pc_reg, pc_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_pc4_reg, id_pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] pc_plus4;
  logic        fetch_evt;
  logic        stall_evt;
  logic        bubble_evt;

  // Targets are always word aligned; the two low bits of redirect_pc are dropped.
  logic [1:0] unused_redirect_lsbs;
  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_reg + 32'd4;

  // Next-state selection: redirect beats flush beats stall beats normal fetch.
  always_comb begin
    pc_next     = pc_reg;
    inst_next   = inst_reg;
    id_pc_next  = id_pc_reg;
    id_pc4_next = id_pc4_reg;
    valid_next  = valid_reg;
    fetch_evt   = 1'b0;
    stall_evt   = 1'b0;
    bubble_evt  = 1'b0;
    if (redirect_valid) begin
      // The branch is older than whatever caused the stall, so stall is ignored.
      pc_next     = {redirect_pc[31:2], 2'b00};
      inst_next   = NOP_INST;
      id_pc_next  = 32'd0;
      id_pc4_next = 32'd0;
      valid_next  = 1'b0;
      bubble_evt  = 1'b1;
    end else if (flush) begin
      inst_next   = NOP_INST;
      id_pc_next  = 32'd0;
      id_pc4_next = 32'd0;
      valid_next  = 1'b0;
      bubble_evt  = 1'b1;
      if (!stall) begin
        pc_next = pc_plus4;
      end
    end else if (stall) begin
      stall_evt = 1'b1;
    end else begin
      pc_next     = pc_plus4;
      inst_next   = imem_rdata;
      id_pc_next  = pc_reg;
      id_pc4_next = pc_plus4;
      valid_next  = 1'b1;
      fetch_evt   = 1'b1;
    end
  end

  // PC and IF/ID register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= RESET_PC;
      inst_reg   <= NOP_INST;
      id_pc_reg  <= 32'd0;
      id_pc4_reg <= 32'd0;
      valid_reg  <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      inst_reg   <= inst_next;
      id_pc_reg  <= id_pc_next;
      id_pc4_reg <= id_pc4_next;
      valid_reg  <= valid_next;
    end
  end

  // ROM address uses only the low word bits; upper PC bits alias.
  assign imem_addr      = pc_reg[IMEM_AW+1:2];
  assign pc             = pc_reg;
  assign if_id_inst     = inst_reg;
  assign if_id_pc       = id_pc_reg;
  assign if_id_pc_plus4 = id_pc4_reg;
  assign if_id_valid    = valid_reg;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg, stall_cnt_reg, bubble_cnt_reg;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt_reg  <= 32'd0;
      stall_cnt_reg  <= 32'd0;
      bubble_cnt_reg <= 32'd0;
    end else begin
      if (fetch_evt)  fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
      if (stall_evt)  stall_cnt_reg  <= stall_cnt_reg + 32'd1;
      if (bubble_evt) bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign fetch_cnt  = fetch_cnt_reg;
  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`else
  // Event strobes only feed the optional counters.
  logic unused_evts;
  assign unused_evts = fetch_evt ^ stall_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: two instances, one with the
// default reset PC and one with a reset PC near the top of the address space.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc, if_id_inst, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid;

  logic        reset2;
  logic        tie0 = 1'b0;
  logic [31:0] tie0_32 = 32'd0;
  logic [5:0]  imem_addr2;
  logic [31:0] imem_rdata2;
  logic [31:0] pc2, if_id_inst2, if_id_pc2, if_id_pc_plus42;
  logic        if_id_valid2;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, bubble_cnt;
  logic [31:0] fetch_cnt2, stall_cnt2, bubble_cnt2;
`endif

  logic [31:0] rom [64];
  int n_cmp = 0;
  int n_bad = 0;
  logic [128:0] exp_st;
  wire  [128:0] st  = {pc, if_id_inst, if_id_pc, if_id_pc_plus4, if_id_valid};
  wire  [128:0] st2 = {pc2, if_id_inst2, if_id_pc2, if_id_pc_plus42, if_id_valid2};

  assign imem_rdata  = rom[imem_addr];
  assign imem_rdata2 = rom[imem_addr2];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(tie0), .flush(tie0),
    .redirect_valid(tie0), .redirect_pc(tie0_32),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .pc(pc2),
    .if_id_inst(if_id_inst2), .if_id_pc(if_id_pc2),
    .if_id_pc_plus4(if_id_pc_plus42), .if_id_valid(if_id_valid2)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
`endif
  );

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    exp_st = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL reset_state: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("reset_state: %h", st);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_normal();
    for (int n = 1; n <= 4; n++) begin
      tick();
      exp_st = {32'(4*n), 32'h1000_0000 + 32'(n-1), 32'(4*(n-1)), 32'(4*n), 1'b1};
      n_cmp++;
      if (st !== exp_st) begin
        $display("FAIL normal_edge%0d: got %h want %h", n, st, exp_st);
        n_bad++;
      end
      $display("normal edge %0d: %h", n, st);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_st = {32'h10, 32'h1000_0003, 32'h0C, 32'h10, 1'b1};
      n_cmp++;
      if (st !== exp_st) begin
        $display("FAIL stall_hold%0d: got %h want %h", k, st, exp_st);
        n_bad++;
      end
      $display("stall edge %0d: %h", k, st);
    end
    stall = 1'b0;
    tick();
    exp_st = {32'h14, 32'h1000_0004, 32'h10, 32'h14, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL stall_release: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("stall release: %h", st);
    tick();
    exp_st = {32'h18, 32'h1000_0005, 32'h14, 32'h18, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL stall_once: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("after release: %h", st);
  endtask

  task automatic test_redirect_over_stall();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    stall          = 1'b1;
    tick();
    exp_st = {32'h40, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL redirect_stall: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("redirect+stall: %h", st);
    redirect_valid = 1'b0;
    stall          = 1'b0;
    tick();
    exp_st = {32'h44, 32'h1000_0010, 32'h40, 32'h44, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL redirect_target_fetch: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("redirect target fetch: %h", st);
  endtask

  task automatic test_flush();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_001C;
    tick();
    redirect_valid = 1'b0;
    tick();
    exp_st = {32'h20, 32'h1000_0007, 32'h1C, 32'h20, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL flush_setup: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("flush setup: %h", st);
    flush = 1'b1;
    stall = 1'b1;
    tick();
    exp_st = {32'h20, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL flush_stall: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("flush+stall: %h", st);
    stall = 1'b0;
    tick();
    exp_st = {32'h24, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL flush_only: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("flush only: %h", st);
    flush = 1'b0;
    tick();
    exp_st = {32'h28, 32'h1000_0009, 32'h24, 32'h28, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL flush_resume: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("flush resume: %h", st);
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    tick();
    exp_st = {32'h100, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL b2b_redirect1: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("b2b redirect 1: %h", st);
    redirect_pc = 32'h0000_0203;
    tick();
    exp_st = {32'h200, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL b2b_redirect2: got %h want %h", st, exp_st);
      n_bad++;
    end
    n_cmp++;
    if (imem_addr !== 6'd0) begin
      $display("FAIL alias_addr: got %0d want 0", imem_addr);
      n_bad++;
    end
    $display("b2b redirect 2: %h addr %0d", st, imem_addr);
    redirect_valid = 1'b0;
    tick();
    exp_st = {32'h204, 32'h1000_0000, 32'h200, 32'h204, 1'b1};
    n_cmp++;
    if (st !== exp_st) begin
      $display("FAIL alias_fetch: got %h want %h", st, exp_st);
      n_bad++;
    end
    $display("aliased fetch: %h", st);
  endtask

  task automatic test_pc_wrap();
    n_cmp++;
    if ({pc2, imem_addr2} !== {32'hFFFF_FFF8, 6'd62}) begin
      $display("FAIL wrap_reset: got %h/%0d want fffffff8/62", pc2, imem_addr2);
      n_bad++;
    end
    $display("wrap reset: pc %h addr %0d", pc2, imem_addr2);
    reset2 = 1'b0;
    tick();
    exp_st = {32'hFFFF_FFFC, 32'h1000_003E, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1};
    n_cmp++;
    if (st2 !== exp_st || imem_addr2 !== 6'd63) begin
      $display("FAIL wrap_edge1: got %h/%0d want %h/63", st2, imem_addr2, exp_st);
      n_bad++;
    end
    $display("wrap edge 1: %h addr %0d", st2, imem_addr2);
    tick();
    exp_st = {32'h0, 32'h1000_003F, 32'hFFFF_FFFC, 32'h0, 1'b1};
    n_cmp++;
    if (st2 !== exp_st || imem_addr2 !== 6'd0) begin
      $display("FAIL wrap_edge2: got %h/%0d want %h/0", st2, imem_addr2, exp_st);
      n_bad++;
    end
    $display("wrap edge 2: %h addr %0d", st2, imem_addr2);
    tick();
    exp_st = {32'h4, 32'h1000_0000, 32'h0, 32'h4, 1'b1};
    n_cmp++;
    if (st2 !== exp_st) begin
      $display("FAIL wrap_edge3: got %h want %h", st2, exp_st);
      n_bad++;
    end
    $display("wrap edge 3: %h", st2);
  endtask

  task automatic test_async_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0080;
    #3;
    reset = 1'b1;
    #1;
    exp_st = {32'h0, 32'h0, 32'h0, 32'h0, 1'b0};
    n_cmp++;
    if (st !== exp_st || imem_addr !== 6'd0) begin
      $display("FAIL async_reset: got %h/%0d want %h/0", st, imem_addr, exp_st);
      n_bad++;
    end
    $display("async reset mid-cycle: %h", st);
    redirect_valid = 1'b0;
    tick();
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_cnt();
    n_cmp++;
    if ({fetch_cnt, stall_cnt, bubble_cnt} !== 96'd0) begin
      $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", fetch_cnt, stall_cnt, bubble_cnt);
      n_bad++;
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    stall = 1'b1;
    tick();
    tick();
    stall          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0010;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({fetch_cnt, stall_cnt, bubble_cnt} !== {32'd5, 32'd2, 32'd1}) begin
      $display("FAIL perf_counts: got %0d/%0d/%0d want 5/2/1", fetch_cnt, stall_cnt, bubble_cnt);
      n_bad++;
    end
    $display("perf counters: %0d/%0d/%0d", fetch_cnt, stall_cnt, bubble_cnt);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + 32'(i);
    reset          = 1'b1;
    reset2         = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    test_reset();
    test_normal();
    test_stall();
    test_redirect_over_stall();
    test_flush();
    test_back_to_back();
    test_pc_wrap();
    test_async_reset();
`ifdef IF_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
